// File: rtl/alu_cdb_buffer.sv
// alu_cdb_buffer: in-order completion buffer between the ALU and the CDB arbiter.
// Holds ALU results in a circular FIFO, requests the CDB for the oldest entry,
// and stalls issue while no slot is free.

package cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic [4:0]  completing_reg;
        logic [31:0] result;
    } CDB_REG_PACKET;
endpackage

module alu_cdb_buffer
    import cdb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  CDB_REG_PACKET       alu_result,
    input  logic                squash,
    input  logic                cdb_grant,
    output logic                cdb_req,
    output CDB_REG_PACKET       cdb_packet,
    output logic                alu_stall,
    output logic [CNT_W-1:0]    free_slots,
    output logic                overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    CDB_REG_PACKET          entries_q [DEPTH];
    CDB_REG_PACKET          entries_d [DEPTH];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   enq, deq;

    // Outputs depend on registered state only, so results never pass straight through.
    always_comb begin
        cdb_req    = (count_q != '0);
        alu_stall  = (count_q == CNT_W'(DEPTH));
        free_slots = CNT_W'(DEPTH) - count_q;
        overflow   = overflow_q;
        cdb_packet = '0;
        if (cdb_req) begin
            cdb_packet       = entries_q[head_q];
            cdb_packet.valid = 1'b1;
        end
    end

    // Next-state: enqueue at tail, dequeue at head; squash empties the pointers.
    always_comb begin
        enq        = alu_result.valid & ~alu_stall;
        deq        = cdb_req & cdb_grant;
        entries_d  = entries_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        // A result offered while full is dropped; the error stays latched even through squash.
        overflow_d = overflow_q | (alu_result.valid & alu_stall);
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                entries_d[tail_q] = alu_result;
                tail_d            = tail_q + 1'b1;
            end
            if (deq) begin
                head_d = head_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_alu_cdb_buffer.sv
// Directed testbench for alu_cdb_buffer with hand-computed expectations.

module tb_alu_cdb_buffer;
    import cdb_pkg::*;

    logic          clock;
    logic          reset;
    CDB_REG_PACKET alu_result;
    logic          squash;
    logic          cdb_grant;
    logic          cdb_req;
    CDB_REG_PACKET cdb_packet;
    logic          alu_stall;
    logic [2:0]    free_slots;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    alu_cdb_buffer #(.DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .alu_result (alu_result),
        .squash     (squash),
        .cdb_grant  (cdb_grant),
        .cdb_req    (cdb_req),
        .cdb_packet (cdb_packet),
        .alu_stall  (alu_stall),
        .free_slots (free_slots),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d);
        alu_result.valid          = v;
        alu_result.completing_reg = r;
        alu_result.result         = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0);
        squash = 1'b0;
        cdb_grant = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", cdb_req); end
        n_checks++; if (cdb_packet !== 38'd0) begin n_fail++; $display("FAIL reset_pkt got %h want 0", cdb_packet); end
        n_checks++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", alu_stall); end
        n_checks++; if (free_slots !== 3'd4) begin n_fail++; $display("FAIL reset_free got %0d want 4", free_slots); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
    endtask

    task automatic test_single();
        CDB_REG_PACKET exp;
        drive(1'b1, 5'd5, 32'h0000_0007);
        cdb_grant = 1'b1;
        tick();
        exp = '{valid: 1'b1, completing_reg: 5'd5, result: 32'h7};
        n_checks++; if (cdb_req !== 1'b1) begin n_fail++; $display("FAIL single_req got %b want 1", cdb_req); end
        n_checks++; if (cdb_packet !== exp) begin n_fail++; $display("FAIL single_pkt got %h want %h", cdb_packet, exp); end
        drive(1'b0, 5'd0, 32'd0);
        tick();
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL single_drain_req got %b want 0", cdb_req); end
        n_checks++; if (free_slots !== 3'd4) begin n_fail++; $display("FAIL single_drain_free got %0d want 4", free_slots); end
        cdb_grant = 1'b0;
    endtask

    task automatic test_fill_overflow();
        CDB_REG_PACKET exp;
        cdb_grant = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'(10 * i));
            tick();
        end
        n_checks++; if (alu_stall !== 1'b1) begin n_fail++; $display("FAIL fill_stall got %b want 1", alu_stall); end
        n_checks++; if (free_slots !== 3'd0) begin n_fail++; $display("FAIL fill_free got %0d want 0", free_slots); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_early got %b want 0", overflow); end
        drive(1'b1, 5'd9, 32'd90);
        tick();
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got %b want 1", overflow); end
        drive(1'b0, 5'd0, 32'd0);
        cdb_grant = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp = '{valid: 1'b1, completing_reg: 5'(i), result: 32'(10 * i)};
            n_checks++; if (cdb_packet !== exp) begin n_fail++; $display("FAIL drain_pkt%0d got %h want %h", i, cdb_packet, exp); end
            tick();
            if (i == 1) begin
                n_checks++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL drain_stall got %b want 0", alu_stall); end
            end
        end
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", cdb_req); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        cdb_grant = 1'b0;
    endtask

    task automatic test_stream();
        CDB_REG_PACKET exp;
        cdb_grant = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'(16 + i), 32'hA000_0000 + 32'(i));
            tick();
            exp = '{valid: 1'b1, completing_reg: 5'(16 + i), result: 32'hA000_0000 + 32'(i)};
            n_checks++; if (cdb_packet !== exp) begin n_fail++; $display("FAIL stream_pkt%0d got %h want %h", i, cdb_packet, exp); end
            n_checks++; if (free_slots !== 3'd3) begin n_fail++; $display("FAIL stream_free%0d got %0d want 3", i, free_slots); end
            n_checks++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL stream_stall%0d got %b want 0", i, alu_stall); end
        end
        drive(1'b0, 5'd0, 32'd0);
        tick();
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL stream_end got %b want 0", cdb_req); end
        cdb_grant = 1'b0;
    endtask

    task automatic test_full_enq_deq();
        CDB_REG_PACKET exp;
        do_reset();
        for (int i = 11; i <= 14; i++) begin
            drive(1'b1, 5'(i), 32'(i * 3));
            tick();
        end
        drive(1'b1, 5'd15, 32'd45);
        cdb_grant = 1'b1;
        tick();
        drive(1'b0, 5'd0, 32'd0);
        n_checks++; if (free_slots !== 3'd1) begin n_fail++; $display("FAIL fullx_free got %0d want 1", free_slots); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fullx_ovf got %b want 1", overflow); end
        for (int i = 12; i <= 14; i++) begin
            exp = '{valid: 1'b1, completing_reg: 5'(i), result: 32'(i * 3)};
            n_checks++; if (cdb_packet !== exp) begin n_fail++; $display("FAIL fullx_pkt%0d got %h want %h", i, cdb_packet, exp); end
            tick();
        end
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL fullx_empty got %b want 0", cdb_req); end
        cdb_grant = 1'b0;
    endtask

    task automatic test_squash();
        CDB_REG_PACKET exp;
        do_reset();
        for (int i = 21; i <= 23; i++) begin
            drive(1'b1, 5'(i), 32'(i));
            tick();
        end
        drive(1'b1, 5'd24, 32'd24);
        squash = 1'b1;
        cdb_grant = 1'b1;
        tick();
        squash = 1'b0;
        cdb_grant = 1'b0;
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL sq_req got %b want 0", cdb_req); end
        n_checks++; if (free_slots !== 3'd4) begin n_fail++; $display("FAIL sq_free got %0d want 4", free_slots); end
        n_checks++; if (cdb_packet !== 38'd0) begin n_fail++; $display("FAIL sq_pkt got %h want 0", cdb_packet); end
        drive(1'b1, 5'd25, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        exp = '{valid: 1'b1, completing_reg: 5'd25, result: 32'hDEAD_BEEF};
        n_checks++; if (cdb_packet !== exp) begin n_fail++; $display("FAIL sq_new got %h want %h", cdb_packet, exp); end
        n_checks++; if (free_slots !== 3'd3) begin n_fail++; $display("FAIL sq_new_free got %0d want 3", free_slots); end
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL sq_drain got %b want 0", cdb_req); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'(i), 32'(i));
            tick();
        end
        drive(1'b0, 5'd0, 32'd0);
        cdb_grant = 1'b1;
        tick();
        tick();
        cdb_grant = 1'b0;
        n_checks++; if (free_slots !== 3'd2) begin n_fail++; $display("FAIL mid_free got %0d want 2", free_slots); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL mid_ovf got %b want 1", overflow); end
        reset = 1'b1;
        drive(1'b1, 5'd7, 32'd7);
        cdb_grant = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        cdb_grant = 1'b0;
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL mid_req got %b want 0", cdb_req); end
        n_checks++; if (cdb_packet !== 38'd0) begin n_fail++; $display("FAIL mid_pkt got %h want 0", cdb_packet); end
        n_checks++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL mid_stall got %b want 0", alu_stall); end
        n_checks++; if (free_slots !== 3'd4) begin n_fail++; $display("FAIL mid_rfree got %0d want 4", free_slots); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rovf got %b want 0", overflow); end
    endtask

    initial begin
        reset = 1'b1;
        squash = 1'b0;
        cdb_grant = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        test_reset();
        test_single();
        test_fill_overflow();
        test_stream();
        test_full_enq_deq();
        test_squash();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
